// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse_stretch event-to-level generator:
// per-channel state encoding and the timer width helper.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Timer must hold the larger of the two reload values (cycles - 1).
  function automatic int timer_width(input int high_cyc, input int gap_cyc);
    int max_cyc;
    max_cyc = (high_cyc > gap_cyc) ? high_cyc : gap_cyc;
    return (max_cyc < 2) ? 1 : $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// Single pulse_stretch channel: IDLE/HIGH/GAP FSM, down-counter timer,
// saturating pending counter and sticky overflow flag.
// Optional retrigger mode: define PULSE_STRETCH_RETRIG_EN.
module pulse_stretch_ch
  import pulse_stretch_pkg::*;
#(
  parameter int HIGH_CYC = 16,
  parameter int GAP_CYC  = 4,
  parameter int PEND_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ev,
  input  logic clr,
  output logic lvl,
  output logic busy,
  output logic ovf
);

  localparam int TW = timer_width(HIGH_CYC, GAP_CYC);
  localparam logic [TW-1:0]     HIGH_LOAD = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0]     GAP_LOAD  = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [TW-1:0]     TIMER_ONE = TW'(1);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  state_t            state_reg, state_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic [PEND_W-1:0] pend_reg, pend_next;
  logic              ovf_reg, ovf_next;
  logic              ev_eff;
  logic              pend_nz;
  logic              queue_ev;

  // A clear discards any event that coincides with it.
  assign ev_eff  = ev & ~clr;
  assign pend_nz = (pend_reg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      timer_reg <= '0;
      pend_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      pend_reg  <= pend_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pend_next  = pend_reg;
    ovf_next   = ovf_reg;
    queue_ev   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A new event starts directly; otherwise replay one pending event.
        if (ev_eff || (pend_nz && !clr)) begin
          state_next = ST_HIGH;
          timer_next = HIGH_LOAD;
          if (!ev_eff) pend_next = pend_reg - PEND_ONE;
        end
      end
      ST_HIGH: begin
        if (timer_reg == '0) begin
          if (GAP_CYC > 0) begin
            state_next = ST_GAP;
            timer_next = GAP_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          timer_next = timer_reg - TIMER_ONE;
        end
`ifdef PULSE_STRETCH_RETRIG_EN
        if (ev_eff) begin
          state_next = ST_HIGH;
          timer_next = HIGH_LOAD;
        end
`else
        queue_ev = ev_eff;
`endif
      end
      ST_GAP: begin
        if (timer_reg == '0) state_next = ST_IDLE;
        else                 timer_next = timer_reg - TIMER_ONE;
        queue_ev = ev_eff;
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase

    if (queue_ev) begin
      if (pend_reg == PEND_MAX) ovf_next  = 1'b1;
      else                      pend_next = pend_reg + PEND_ONE;
    end
    if (clr) begin
      pend_next = '0;
      ovf_next  = 1'b0;
    end
  end

  assign lvl  = (state_reg == ST_HIGH);
  assign busy = (state_reg != ST_IDLE);
  assign ovf  = ovf_reg;

endmodule

// File: rtl/pulse_stretch.sv
// Multi-channel event-to-level pulse stretcher; CH independent channels
// sharing clk, rst and clr. Optional retrigger mode: PULSE_STRETCH_RETRIG_EN.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int CH       = 4,
  parameter int HIGH_CYC = 16,
  parameter int GAP_CYC  = 4,
  parameter int PEND_W   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] ev,
  input  logic          clr,
  output logic [CH-1:0] lvl,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] ovf
);

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : gen_ch
      pulse_stretch_ch #(
        .HIGH_CYC(HIGH_CYC),
        .GAP_CYC (GAP_CYC),
        .PEND_W  (PEND_W)
      ) u_ch (
        .clk (clk),
        .rst (rst),
        .ev  (ev[gi]),
        .clr (clr),
        .lvl (lvl[gi]),
        .busy(busy[gi]),
        .ovf (ovf[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch: expected pulses (start cycle, length)
// are queued when events are driven and matched against observed lvl pulses.
module tb_pulse_stretch;

  typedef struct {
    int start;
    int len;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ev0, ev1;
  logic       clr0, clr1;
  logic [3:0] lvl0, busy0, ovf0;
  logic [3:0] lvl1, busy1, ovf1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  pulse_t exp0[4][$];
  pulse_t obs0[4][$];
  pulse_t exp1[$];
  pulse_t obs1[$];
  logic [3:0] prev0 = '0;
  logic       prev1 = 1'b0;
  int         start0[4];
  int         start1;

  pulse_stretch #(.CH(4), .HIGH_CYC(16), .GAP_CYC(4), .PEND_W(3)) dut0 (
    .clk(clk), .rst(rst), .ev(ev0), .clr(clr0),
    .lvl(lvl0), .busy(busy0), .ovf(ovf0)
  );

  pulse_stretch #(.CH(4), .HIGH_CYC(16), .GAP_CYC(0), .PEND_W(3)) dut1 (
    .clk(clk), .rst(rst), .ev(ev1), .clr(clr1),
    .lvl(lvl1), .busy(busy1), .ovf(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: cycle k is the interval following the k-th rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lvl0[i] && !prev0[i]) start0[i] <= cyc;
      if (!lvl0[i] && prev0[i]) obs0[i].push_back(pulse_t'{start0[i], cyc - start0[i]});
    end
    if (lvl1[0] && !prev1) start1 <= cyc;
    if (!lvl1[0] && prev1) obs1.push_back(pulse_t'{start1, cyc - start1});
    prev0 <= lvl0;
    prev1 <= lvl1[0];
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Event high during cycle c, sampled at the edge that starts cycle c+1.
  task automatic pulse0(input int ch, input int c);
    at_cyc(c);
    ev0 = '0;
    ev0[ch] = 1'b1;
    @(negedge clk);
    ev0 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ev0 = '0; ev1 = '0; clr0 = 1'b0; clr1 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (lvl0 !== 4'b0) begin n_fail++; $display("FAIL reset_lvl: got %b expected 0000", lvl0); end
    n_checks++;
    if (busy0 !== 4'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", busy0); end
    n_checks++;
    if (ovf0 !== 4'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0000", ovf0); end
    n_checks++;
    if (lvl1 !== 4'b0) begin n_fail++; $display("FAIL reset_lvl_gap0: got %b expected 0000", lvl1); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: lvl=%b busy=%b ovf=%b", lvl0, busy0, ovf0);
  endtask

  task automatic test_single();
    pulse_t e, o;
    int base;
    base = cyc;
    exp0[0].push_back(pulse_t'{base + 11, 16});
    pulse0(0, base + 10);
    at_cyc(base + 30);
    n_checks++;
    if (busy0[0] !== 1'b1) begin n_fail++; $display("FAIL single_busy_gap: got %b expected 1", busy0[0]); end
    at_cyc(base + 31);
    n_checks++;
    if (busy0[0] !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", busy0[0]); end
    at_cyc(base + 40);
    while (exp0[0].size() != 0) begin
      e = exp0[0].pop_front();
      n_checks++;
      if (obs0[0].size() == 0) begin
        n_fail++; $display("FAIL single_pulse: got none expected start %0d len %0d", e.start - base, e.len);
      end else begin
        o = obs0[0].pop_front();
        $display("single: pulse start %0d len %0d", o.start - base, o.len);
        if (o.start !== e.start || o.len !== e.len) begin
          n_fail++; $display("FAIL single_pulse: got start %0d len %0d expected start %0d len %0d", o.start - base, o.len, e.start - base, e.len);
        end
      end
    end
    n_checks++;
    if (obs0[0].size() != 0) begin n_fail++; $display("FAIL single_extra: got %0d extra pulses expected 0", obs0[0].size()); obs0[0].delete(); end
  endtask

  task automatic test_back_to_back();
    pulse_t e, o;
    int base;
    base = cyc;
`ifdef PULSE_STRETCH_RETRIG_EN
    exp0[1].push_back(pulse_t'{base + 11, 20});
`else
    for (int k = 0; k < 3; k++) exp0[1].push_back(pulse_t'{base + 11 + 21 * k, 16});
`endif
    pulse0(1, base + 10);
    pulse0(1, base + 12);
    pulse0(1, base + 14);
    at_cyc(base + 80);
    n_checks++;
    if (ovf0[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b expected 0", ovf0[1]); end
    while (exp0[1].size() != 0) begin
      e = exp0[1].pop_front();
      n_checks++;
      if (obs0[1].size() == 0) begin
        n_fail++; $display("FAIL b2b_pulse: got none expected start %0d len %0d", e.start - base, e.len);
      end else begin
        o = obs0[1].pop_front();
        $display("b2b: pulse start %0d len %0d", o.start - base, o.len);
        if (o.start !== e.start || o.len !== e.len) begin
          n_fail++; $display("FAIL b2b_pulse: got start %0d len %0d expected start %0d len %0d", o.start - base, o.len, e.start - base, e.len);
        end
      end
    end
    n_checks++;
    if (obs0[1].size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra pulses expected 0", obs0[1].size()); obs0[1].delete(); end
  endtask

  task automatic test_saturation();
    pulse_t e, o;
    int base;
    logic exp_ovf;
    base = cyc;
`ifdef PULSE_STRETCH_RETRIG_EN
    exp_ovf = 1'b0;
    exp0[2].push_back(pulse_t'{base + 11, 25});
`else
    exp_ovf = 1'b1;
    for (int k = 0; k < 8; k++) exp0[2].push_back(pulse_t'{base + 11 + 21 * k, 16});
`endif
    pulse0(2, base + 10);
    for (int c = 12; c < 20; c++) pulse0(2, base + c);
    at_cyc(base + 21);
    n_checks++;
    if (ovf0[2] !== exp_ovf) begin n_fail++; $display("FAIL sat_ovf_set: got %b expected %b", ovf0[2], exp_ovf); end
    at_cyc(base + 190);
    n_checks++;
    if (ovf0[2] !== exp_ovf) begin n_fail++; $display("FAIL sat_ovf_sticky: got %b expected %b", ovf0[2], exp_ovf); end
    while (exp0[2].size() != 0) begin
      e = exp0[2].pop_front();
      n_checks++;
      if (obs0[2].size() == 0) begin
        n_fail++; $display("FAIL sat_pulse: got none expected start %0d len %0d", e.start - base, e.len);
      end else begin
        o = obs0[2].pop_front();
        $display("sat: pulse start %0d len %0d", o.start - base, o.len);
        if (o.start !== e.start || o.len !== e.len) begin
          n_fail++; $display("FAIL sat_pulse: got start %0d len %0d expected start %0d len %0d", o.start - base, o.len, e.start - base, e.len);
        end
      end
    end
    n_checks++;
    if (obs0[2].size() != 0) begin n_fail++; $display("FAIL sat_extra: got %0d extra pulses expected 0", obs0[2].size()); obs0[2].delete(); end
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    n_checks++;
    if (ovf0 !== 4'b0) begin n_fail++; $display("FAIL sat_clr_ovf: got %b expected 0000", ovf0); end
    $display("sat: after clr ovf=%b", ovf0);
  endtask

  task automatic test_gap0();
    pulse_t e, o;
    int base;
    logic exp_busy;
    base = cyc;
`ifdef PULSE_STRETCH_RETRIG_EN
    exp_busy = 1'b1;
    exp1.push_back(pulse_t'{base + 11, 18});
`else
    exp_busy = 1'b0;
    exp1.push_back(pulse_t'{base + 11, 16});
    exp1.push_back(pulse_t'{base + 28, 16});
`endif
    at_cyc(base + 10); ev1[0] = 1'b1; @(negedge clk); ev1[0] = 1'b0;
    at_cyc(base + 12); ev1[0] = 1'b1; @(negedge clk); ev1[0] = 1'b0;
    at_cyc(base + 27);
    n_checks++;
    if (busy1[0] !== exp_busy) begin n_fail++; $display("FAIL gap0_idle_cycle: got busy %b expected %b", busy1[0], exp_busy); end
    at_cyc(base + 60);
    while (exp1.size() != 0) begin
      e = exp1.pop_front();
      n_checks++;
      if (obs1.size() == 0) begin
        n_fail++; $display("FAIL gap0_pulse: got none expected start %0d len %0d", e.start - base, e.len);
      end else begin
        o = obs1.pop_front();
        $display("gap0: pulse start %0d len %0d", o.start - base, o.len);
        if (o.start !== e.start || o.len !== e.len) begin
          n_fail++; $display("FAIL gap0_pulse: got start %0d len %0d expected start %0d len %0d", o.start - base, o.len, e.start - base, e.len);
        end
      end
    end
    n_checks++;
    if (obs1.size() != 0) begin n_fail++; $display("FAIL gap0_extra: got %0d extra pulses expected 0", obs1.size()); obs1.delete(); end
  endtask

  task automatic test_retrig();
    pulse_t e, o;
    int base;
    base = cyc;
`ifdef PULSE_STRETCH_RETRIG_EN
    exp0[3].push_back(pulse_t'{base + 11, 26});
`else
    exp0[3].push_back(pulse_t'{base + 11, 16});
    exp0[3].push_back(pulse_t'{base + 32, 16});
`endif
    pulse0(3, base + 10);
    pulse0(3, base + 20);
    at_cyc(base + 70);
    n_checks++;
    if (ovf0[3] !== 1'b0) begin n_fail++; $display("FAIL retrig_ovf: got %b expected 0", ovf0[3]); end
    while (exp0[3].size() != 0) begin
      e = exp0[3].pop_front();
      n_checks++;
      if (obs0[3].size() == 0) begin
        n_fail++; $display("FAIL retrig_pulse: got none expected start %0d len %0d", e.start - base, e.len);
      end else begin
        o = obs0[3].pop_front();
        $display("retrig: pulse start %0d len %0d", o.start - base, o.len);
        if (o.start !== e.start || o.len !== e.len) begin
          n_fail++; $display("FAIL retrig_pulse: got start %0d len %0d expected start %0d len %0d", o.start - base, o.len, e.start - base, e.len);
        end
      end
    end
    n_checks++;
    if (obs0[3].size() != 0) begin n_fail++; $display("FAIL retrig_extra: got %0d extra pulses expected 0", obs0[3].size()); obs0[3].delete(); end
  endtask

  task automatic test_clr_wins();
    pulse_t e, o;
    int base;
    base = cyc;
    exp0[3].push_back(pulse_t'{base + 11, 16});
    pulse0(3, base + 10);
    at_cyc(base + 15);
    ev0[3] = 1'b1;
    clr0 = 1'b1;
    @(negedge clk);
    ev0 = '0;
    clr0 = 1'b0;
    n_checks++;
    if (lvl0[3] !== 1'b1) begin n_fail++; $display("FAIL clr_no_abort: got lvl %b expected 1", lvl0[3]); end
    at_cyc(base + 50);
    n_checks++;
    if (ovf0 !== 4'b0) begin n_fail++; $display("FAIL clr_ovf: got %b expected 0000", ovf0); end
    while (exp0[3].size() != 0) begin
      e = exp0[3].pop_front();
      n_checks++;
      if (obs0[3].size() == 0) begin
        n_fail++; $display("FAIL clr_pulse: got none expected start %0d len %0d", e.start - base, e.len);
      end else begin
        o = obs0[3].pop_front();
        $display("clr: pulse start %0d len %0d", o.start - base, o.len);
        if (o.start !== e.start || o.len !== e.len) begin
          n_fail++; $display("FAIL clr_pulse: got start %0d len %0d expected start %0d len %0d", o.start - base, o.len, e.start - base, e.len);
        end
      end
    end
    n_checks++;
    if (obs0[3].size() != 0) begin n_fail++; $display("FAIL clr_extra: got %0d extra pulses expected 0", obs0[3].size()); obs0[3].delete(); end
  endtask

  task automatic test_async_reset();
    int base;
    logic exp_ovf;
    base = cyc;
`ifdef PULSE_STRETCH_RETRIG_EN
    exp_ovf = 1'b0;
`else
    exp_ovf = 1'b1;
`endif
    pulse0(0, base + 10);
    for (int c = 11; c < 20; c++) pulse0(0, base + c);
    at_cyc(base + 21);
    n_checks++;
    if (ovf0[0] !== exp_ovf) begin n_fail++; $display("FAIL arst_pre_ovf: got %b expected %b", ovf0[0], exp_ovf); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (lvl0 !== 4'b0) begin n_fail++; $display("FAIL arst_lvl: got %b expected 0000", lvl0); end
    n_checks++;
    if (busy0 !== 4'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0000", busy0); end
    n_checks++;
    if (ovf0 !== 4'b0) begin n_fail++; $display("FAIL arst_ovf: got %b expected 0000", ovf0); end
    $display("arst: lvl=%b busy=%b ovf=%b during reset", lvl0, busy0, ovf0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    obs0[0].delete();
    base = cyc;
    at_cyc(base + 60);
    n_checks++;
    if (obs0[0].size() != 0) begin n_fail++; $display("FAIL arst_resume: got %0d pulses expected 0", obs0[0].size()); end
    n_checks++;
    if (busy0 !== 4'b0) begin n_fail++; $display("FAIL arst_busy_after: got %b expected 0000", busy0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_gap0();
    test_retrig();
    test_clr_wins();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Multi-channel event-to-level generator that turns single-cycle event pulses (as produced by the input one-pulse/collision conditioning stages) into fixed-width level pulses, with a minimum low gap between them, to drive LEDs, sound triggers and sprite-flash effects. Events arriving while a channel is busy are counted in a saturating per-channel pending counter and replayed back-to-back, so no event is lost up to counter capacity. It sits between the conditioned game-event pulses and the slow-reacting output consumers.

## Interface
- CH, 4, number of independent channels
- HIGH_CYC, 16, cycles each output pulse stays high (legal ≥1)
- GAP_CYC, 4, minimum low cycles after each pulse (legal ≥0; 0 = no gap)
- PEND_W, 3, width of per-channel pending counter (capacity 2^PEND_W−1)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ev  in  CH  single-cycle event pulse per channel
- clr  in  1  synchronous clear of all pending counts and overflow flags
- lvl  out  CH  stretched level output per channel
- busy  out  CH  channel in HIGH or GAP state
- ovf  out  CH  sticky flag: an event was dropped at pending saturation

## Operation
- Per-channel FSM: IDLE, HIGH, GAP. One down-counter timer per channel, width clog2(max(HIGH_CYC,GAP_CYC)+1).
- IDLE: if ev[i]=1 or pend[i]≠0 → HIGH, timer=HIGH_CYC−1. If start is by pend (ev=0), pend decrements; if ev=1, the event is consumed directly (pend unchanged).
- HIGH: lvl[i]=1. Timer decrements each cycle; at timer=0 → GAP with timer=GAP_CYC−1, or → IDLE if GAP_CYC=0.
- GAP: lvl[i]=0, busy[i]=1. At timer=0 → IDLE.
- Events arriving in HIGH or GAP increment pend[i]. If pend[i] is at max, the event is dropped, pend holds, ovf[i] sets.
- Event in the IDLE cycle where pend≠0: pend consumed for the start; the new event increments pend (net unchanged).
- clr: pend and ovf of all channels zero next cycle; the current HIGH/GAP is not aborted. clr and ev in the same cycle: clr wins (event discarded, ovf not set).
- busy = (state≠IDLE); ovf clears only by clr or rst.

## Timing
- Reset: all states IDLE, timers 0, pend 0; lvl=0, busy=0, ovf=0 asynchronously.
- Latency: ev high on edge n → lvl high from edge n+1 for exactly HIGH_CYC cycles, then ≥GAP_CYC low cycles.
- Back-to-back replay: next pulse rises on the cycle after the last GAP cycle (period HIGH_CYC+GAP_CYC+1 with GAP_CYC>0; HIGH_CYC+1 with GAP_CYC=0, including one low IDLE cycle).
- Outputs are registered; no combinational path from ev to lvl.
- Channels are fully independent; simultaneous events on different channels never interact.

## Configuration
- PULSE_STRETCH_RETRIG_EN defined: an ev[i] arriving while in HIGH reloads timer to HIGH_CYC−1 (pulse extended) and is not counted in pend; events in GAP still count.
- Undefined: behaviour exactly as in Operation (every event yields its own pulse).

## Structure
- Shared package: state encoding constants (IDLE/HIGH/GAP), timer-width helper function.
- One sub-module pulse_stretch_ch (single channel: FSM, timer, pend, ovf); top instantiates CH copies via generate and fans out clr.

## Test plan
- Single ev[0] at cycle 10, defaults → lvl[0] high cycles 11–26, busy[0] high 11–30, low from 31.
- Three ev[1] at cycles 10, 12, 14 → three pulses starting at 11, 32, 53; pend peaks at 2; ovf[1]=0.
- Nine ev[2] during one HIGH (PEND_W=3) → pend saturates at 7, ovf[2]=1, 8 pulses total; clr then zeroes ovf.
- GAP_CYC=0, two events → pulses at 11–26 and 28–43.
- rst asserted mid-HIGH → lvl, busy, pend, ovf zero immediately; no pulse resumes after release.
- With PULSE_STRETCH_RETRIG_EN, ev[3] at 10 and 20 → single pulse 11–36, pend stays 0.
